// File: rtl/scale_coord_gen.sv
// Output-raster walker for the scaler: produces clamped source coordinates and
// bilinear weights, one per accepted valid/ready beat, with config latched per frame.
//
// state | meaning
// IDLE  | waiting for an accepted frame_start; outputs forced to 0
// RUN   | walking the output raster, one coordinate per transfer
module scale_coord_gen #(
  parameter int unsigned SCALE_WIDTH = 15,
  parameter int unsigned FRAC_BITS   = 12,
  parameter int unsigned NUM_WIDTH   = 11,
  parameter int unsigned WEIGHT_BITS = 8,
  parameter int unsigned SRC_H_MAX   = 640,
  parameter int unsigned SRC_V_MAX   = 360
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   frame_start,
  input  logic [SCALE_WIDTH-1:0] x_scale,
  input  logic [SCALE_WIDTH-1:0] y_scale,
  input  logic [NUM_WIDTH-1:0]   target_h_num,
  input  logic [NUM_WIDTH-1:0]   target_v_num,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_WIDTH-1:0]   src_x,
  output logic [NUM_WIDTH-1:0]   src_y,
  output logic [WEIGHT_BITS-1:0] frac_x,
  output logic [WEIGHT_BITS-1:0] frac_y,
  output logic                   line_start,
  output logic                   line_end,
  output logic                   frame_end,
  output logic                   busy
);

  localparam int unsigned ACC_W = NUM_WIDTH + FRAC_BITS;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [NUM_WIDTH-1:0] X_LIM = NUM_WIDTH'(SRC_H_MAX - 1);
  localparam logic [NUM_WIDTH-1:0] Y_LIM = NUM_WIDTH'(SRC_V_MAX - 1);

  logic [0:0]             state_q, state_d;
  logic [ACC_W-1:0]       acc_x_q, acc_x_d;
  logic [ACC_W-1:0]       acc_y_q, acc_y_d;
  logic [NUM_WIDTH-1:0]   h_cnt_q, h_cnt_d;
  logic [NUM_WIDTH-1:0]   v_cnt_q, v_cnt_d;
  logic [SCALE_WIDTH-1:0] xs_q, xs_d;
  logic [SCALE_WIDTH-1:0] ys_q, ys_d;
  logic [NUM_WIDTH-1:0]   th_q, th_d;
  logic [NUM_WIDTH-1:0]   tv_q, tv_d;

  logic                   run;
  logic                   xfer;
  logic                   last_h;
  logic                   last_v;
  logic [NUM_WIDTH-1:0]   int_x;
  logic [NUM_WIDTH-1:0]   int_y;
  logic                   clamp_x;
  logic                   clamp_y;

  assign run     = (state_q == S_RUN);
  assign xfer    = run & out_ready;
  assign last_h  = (h_cnt_q == th_q - NUM_WIDTH'(1));
  assign last_v  = (v_cnt_q == tv_q - NUM_WIDTH'(1));
  assign int_x   = acc_x_q[ACC_W-1:FRAC_BITS];
  assign int_y   = acc_y_q[ACC_W-1:FRAC_BITS];
  assign clamp_x = (int_x > X_LIM);
  assign clamp_y = (int_y > Y_LIM);

  always_comb begin
    state_d = state_q;
    acc_x_d = acc_x_q;
    acc_y_d = acc_y_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    th_d    = th_q;
    tv_d    = tv_q;
    case (state_q)
      S_IDLE: begin
        if (frame_start && (target_h_num != '0) && (target_v_num != '0)) begin
          state_d = S_RUN;
          xs_d    = x_scale;
          ys_d    = y_scale;
          th_d    = target_h_num;
          tv_d    = target_v_num;
          acc_x_d = '0;
          acc_y_d = '0;
          h_cnt_d = '0;
          v_cnt_d = '0;
        end
      end
      default: begin
        // Registers only move on a transfer, which keeps stalled beats stable.
        if (xfer) begin
          if (last_h) begin
            h_cnt_d = '0;
            acc_x_d = '0;
            acc_y_d = acc_y_q + ACC_W'(ys_q);
            v_cnt_d = v_cnt_q + NUM_WIDTH'(1);
            if (last_v) state_d = S_IDLE;
          end else begin
            h_cnt_d = h_cnt_q + NUM_WIDTH'(1);
            acc_x_d = acc_x_q + ACC_W'(xs_q);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      acc_x_q <= '0;
      acc_y_q <= '0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      xs_q    <= '0;
      ys_q    <= '0;
      th_q    <= '0;
      tv_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_x_q <= acc_x_d;
      acc_y_q <= acc_y_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      th_q    <= th_d;
      tv_q    <= tv_d;
    end
  end

  // Accumulators keep stale values in IDLE, so every output is gated by run.
  assign out_valid  = run;
  assign busy       = run;
  assign src_x      = !run ? '0 : (clamp_x ? X_LIM : int_x);
  assign src_y      = !run ? '0 : (clamp_y ? Y_LIM : int_y);
  assign frac_x     = (!run || clamp_x) ? '0 : acc_x_q[FRAC_BITS-1 -: WEIGHT_BITS];
  assign frac_y     = (!run || clamp_y) ? '0 : acc_y_q[FRAC_BITS-1 -: WEIGHT_BITS];
  assign line_start = run & (h_cnt_q == '0);
  assign line_end   = run & last_h;
  assign frame_end  = run & last_h & last_v;

endmodule

// File: tb/tb_scale_coord_gen.sv
// Scoreboard bench for scale_coord_gen: frames are expanded into expected beats
// by an arithmetic model; a monitor pops and compares on every transfer.
module tb_scale_coord_gen;

  logic        clk = 1'b0;
  logic        rstn;
  logic        frame_start;
  logic [14:0] x_scale, y_scale;
  logic [10:0] target_h_num, target_v_num;
  logic        out_valid, out_ready;
  logic [10:0] src_x, src_y;
  logic [7:0]  frac_x, frac_y;
  logic        line_start, line_end, frame_end, busy;

  always #5 clk = ~clk;

  scale_coord_gen dut (
    .clk(clk), .rstn(rstn), .frame_start(frame_start),
    .x_scale(x_scale), .y_scale(y_scale),
    .target_h_num(target_h_num), .target_v_num(target_v_num),
    .out_valid(out_valid), .out_ready(out_ready),
    .src_x(src_x), .src_y(src_y), .frac_x(frac_x), .frac_y(frac_y),
    .line_start(line_start), .line_end(line_end), .frame_end(frame_end),
    .busy(busy)
  );

  typedef struct {
    int sx, sy, fx, fy;
    bit ls, le, fe;
  } beat_t;

  beat_t exp_q[$];
  int    n_pass = 0, n_total = 0;
  int    beats_done = 0;
  bit    mon_en = 1'b0;
  int    ready_mode = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  function automatic logic [42:0] snap();
    return {src_x, src_y, frac_x, frac_y, line_start, line_end, frame_end, busy, out_valid};
  endfunction

  // Source position of output pixel n is n*step in Q.12; clamp to the last pixel.
  function automatic void push_frame(int xs, int ys, int th, int tv);
    beat_t b;
    for (int v = 0; v < tv; v++) begin
      for (int h = 0; h < th; h++) begin
        int ax, ay;
        ax = h * xs;
        ay = v * ys;
        b.sx = (ax / 4096 > 639) ? 639 : ax / 4096;
        b.fx = (ax / 4096 > 639) ? 0 : (ax / 16) % 256;
        b.sy = (ay / 4096 > 359) ? 359 : ay / 4096;
        b.fy = (ay / 4096 > 359) ? 0 : (ay / 16) % 256;
        b.ls = (h == 0);
        b.le = (h == th - 1);
        b.fe = (h == th - 1) && (v == tv - 1);
        exp_q.push_back(b);
      end
    end
  endfunction

  initial begin
    int k = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = (k % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      k++;
    end
  end

  initial begin
    logic [42:0] held;
    bit held_v = 0, idle_chk = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        held_v = 0;
        idle_chk = 0;
      end else begin
        if (idle_chk) begin
          check("idle_after_frame_end", {out_valid, busy}, 2'b00);
          idle_chk = 0;
        end
        if (held_v) begin
          check("stall_hold", snap(), held);
          held_v = 0;
        end
        if (out_valid) begin
          if (!out_ready) begin
            held = snap();
            held_v = 1;
          end else if (exp_q.size() == 0) begin
            check("unexpected_beat", 1, 0);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            check("src_x", src_x, e.sx);
            check("src_y", src_y, e.sy);
            check("frac_x", frac_x, e.fx);
            check("frac_y", frac_y, e.fy);
            check("flags", {line_start, line_end, frame_end, busy}, {e.ls, e.le, e.fe, 1'b1});
            beats_done++;
            if (e.fe) idle_chk = 1;
          end
        end
      end
    end
  end

  task automatic pulse(int xs, int ys, int th, int tv, bit accept, bit exp_valid);
    @(posedge clk);
    #1;
    x_scale = 15'(xs);
    y_scale = 15'(ys);
    target_h_num = 11'(th);
    target_v_num = 11'(tv);
    frame_start = 1'b1;
    if (accept) push_frame(xs, ys, th, tv);
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    x_scale = 15'($urandom_range(0, 32767));
    y_scale = 15'($urandom_range(0, 32767));
    target_h_num = 11'($urandom_range(0, 2047));
    target_v_num = 11'($urandom_range(0, 2047));
    @(negedge clk);
    check("valid_latency", out_valid, exp_valid);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1;
        break;
      end
    end
    check("frame_done", done, 1);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic run_frame(int xs, int ys, int th, int tv);
    pulse(xs, ys, th, tv, 1, 1);
    wait_idle();
  endtask

  initial begin
    int base;
    bit reached;
    rstn = 1'b0;
    frame_start = 1'b0;
    x_scale = '0;
    y_scale = '0;
    target_h_num = '0;
    target_v_num = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", snap(), 43'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    mon_en = 1'b1;

    ready_mode = 0;
    run_frame(4096, 4096, 4, 2);
    run_frame(2048, 4096, 4, 1);
    ready_mode = 1;
    run_frame(4096, 4096, 4, 2);
    ready_mode = 0;
    run_frame(8192, 4096, 400, 1);
    run_frame(4096, 4096, 1, 3);

    pulse(4096, 4096, 4, 0, 0, 0);
    repeat (4) begin
      @(negedge clk);
      check("ignored_start_idle", {out_valid, busy}, 2'b00);
    end

    pulse(4096, 4096, 4, 2, 1, 1);
    pulse(8192, 8192, 7, 3, 0, 1);
    wait_idle();

    ready_mode = 1;
    base = beats_done;
    pulse(4096, 4096, 4, 2, 1, 1);
    reached = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (beats_done >= base + 3) begin
        reached = 1;
        break;
      end
    end
    check("reach_beat3", reached, 1);
    #2;
    mon_en = 1'b0;
    rstn = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset_outputs", snap(), 43'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {out_valid, busy}, 2'b00);
    mon_en = 1'b1;
    ready_mode = 0;
    run_frame(4096, 4096, 4, 2);

    ready_mode = 2;
    for (int f = 0; f < 6; f++) begin
      run_frame($urandom_range(1, 32767), $urandom_range(1, 32767),
                $urandom_range(1, 40), $urandom_range(1, 60));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/scale_coord_gen.md
Name: scale_coord_gen

Overview:
- Downstream consumer of the key-driven scale configuration (x_scale, y_scale, TARGET_H_NUM, TARGET_V_NUM).
- For each output pixel of a target frame, generates the matching source-pixel coordinate plus bilinear fractional weights.
- Walks the output raster and emits one coordinate per accepted valid/ready beat to the scaler's line-buffer read side.
- Latches the configuration at frame start, so key presses mid-frame never tear a frame.

Parameters:
- SCALE_WIDTH, 15, width of x_scale/y_scale; unsigned Q3.12 step in source pixels per output pixel (4096 = 1.0).
- FRAC_BITS, 12, fractional bits of the scale step.
- NUM_WIDTH, 11, width of target counts and source coordinates.
- WEIGHT_BITS, 8, output weight width; taken as the top WEIGHT_BITS of the fraction.
- SRC_H_MAX, 640, source width; src_x clamp limit.
- SRC_V_MAX, 360, source height; src_y clamp limit.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse requesting a new output frame.
- x_scale  in  SCALE_WIDTH  horizontal step, Q3.12.
- y_scale  in  SCALE_WIDTH  vertical step, Q3.12.
- target_h_num  in  NUM_WIDTH  output pixels per line.
- target_v_num  in  NUM_WIDTH  output lines per frame.
- out_valid  out  1  coordinate beat valid.
- out_ready  in  1  consumer accepts beat.
- src_x  out  NUM_WIDTH  integer source column.
- src_y  out  NUM_WIDTH  integer source row.
- frac_x  out  WEIGHT_BITS  horizontal weight.
- frac_y  out  WEIGHT_BITS  vertical weight.
- line_start  out  1  beat is first pixel of a line.
- line_end  out  1  beat is last pixel of a line.
- frame_end  out  1  beat is last pixel of the frame.
- busy  out  1  high from frame acceptance until last beat accepted.

Behaviour:
- Reset (async, rstn=0): all outputs 0; state IDLE; accumulators, counters and latched config cleared.
- States: IDLE, RUN.
- IDLE -> RUN on frame_start=1 when target_h_num!=0 and target_v_num!=0.
  - On that edge: latch x_scale, y_scale, target_h_num, target_v_num; clear acc_x, acc_y and counters h_cnt, v_cnt; set busy=1.
  - frame_start with either target count 0: ignored; stay IDLE.
- frame_start in RUN: ignored; latched config unchanged.
- Latency: out_valid rises the cycle after frame_start is accepted, carrying pixel (0,0).
- Handshake:
  - Beat transfers on out_valid & out_ready.
  - While out_valid=1 and out_ready=0, every output is held stable.
  - out_valid never drops without a transfer.
  - Back-to-back transfers at one beat per cycle with out_ready held high.
- Arithmetic:
  - acc_x and acc_y are NUM_WIDTH+FRAC_BITS bits wide (23).
  - On each transfer: acc_x += x_scale; h_cnt++.
  - When h_cnt reaches target_h_num-1 on a transfer: h_cnt=0, acc_x=0, acc_y += y_scale, v_cnt++.
  - src_x = acc_x >> FRAC_BITS; frac_x = acc_x[FRAC_BITS-1 -: WEIGHT_BITS]. Same rule for y.
- Clamp:
  - If the integer part exceeds SRC_H_MAX-1, src_x = SRC_H_MAX-1 and frac_x = 0.
  - Same for y against SRC_V_MAX-1.
  - The accumulator itself never saturates; sizing guarantees no wrap for legal counts.
- Flags: line_start = (h_cnt==0); line_end = (h_cnt==target_h_num-1); frame_end = line_end & (v_cnt==target_v_num-1).
- On transfer of the frame_end beat: out_valid=0, busy=0, return to IDLE.
- A frame_start in that same cycle is ignored.
- Frame end to next frame_start acceptance: 1 cycle minimum.
- target_h_num=1: every beat has line_start=line_end=1.
- Reset mid-frame: immediate return to IDLE with outputs 0. No partial beat is emitted after rstn deasserts.

Test Plan:
- x_scale=y_scale=4096, target 4x2, out_ready=1, frame_start pulse:
  - 8 consecutive beats; src_x 0,1,2,3 repeating; src_y 0 then 1; all fracs 0.
  - line_start on beats 0 and 4; frame_end on beat 7; busy drops the cycle after.
- x_scale=2048, y_scale=4096, target 4x1:
  - src_x 0,0,1,1; frac_x 0,128,0,128.
- Backpressure, same config as the first scenario, out_ready toggled 1,0,0,1,...:
  - Held beats keep identical values; the sequence matches the first scenario exactly, with no drop or duplicate.
- x_scale=8192, target_h_num=400, target_v_num=1:
  - Beat 319 gives src_x=638; beats 320..399 give src_x=639, frac_x=0 (clamp).
- Ignored frame_start:
  - frame_start with target_v_num=0: out_valid stays 0, busy stays 0.
  - frame_start mid-RUN with changed x_scale: the current frame keeps its old step.
- Reset mid-frame:
  - rstn low during beat 3 of a 4x2 frame: all outputs 0 asynchronously.
  - After release, a new frame_start restarts at (0,0).
